// File: rtl/block_word_tokenizer.sv
// block_word_tokenizer
//   Front end of the begin/end block checker. It watches a serial ASCII
//   character stream, finds the whole words "begin" and "end", and queues
//   one token per word in a small FIFO. Any other word, and any non-letter
//   byte, produces no token.
//
//   Optional build macro: BLOCK_TOKENIZER_CASE_FOLD_EN
//     defined   : 'A'-'Z' are folded to lowercase before matching
//     undefined : uppercase letters still continue a word but never match
//
//   Ports
//     clk, reset_n          clock, asynchronous active-low reset
//     in_valid/in_char/in_last/in_ready   character input handshake
//                           (in_last implies a delimiter after in_char)
//     tok_valid/tok_kind/tok_ready        token FIFO head, kind 1=begin 0=end
//     fifo_level            current FIFO occupancy
//     word_cnt              tokens pushed since reset, saturating
//
//   state    | meaning
//   S_GAP    | between words
//   S_B..    | prefix of "begin" seen so far (S_B, S_BE, S_BEG, S_BEGI)
//   S_BEGIN  | "begin" complete, waiting for a delimiter
//   S_E, S_EN| prefix of "end" seen so far
//   S_END    | "end" complete, waiting for a delimiter
//   S_WORD   | inside a word that can no longer match
module block_word_tokenizer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_char,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          tok_valid,
  output logic                          tok_kind,
  input  logic                          tok_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              word_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [3:0] {
    S_GAP, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_WORD
  } state_t;

  state_t                state_q, state_d;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic       is_upper, is_letter, accept, push, push_kind, pop;
  logic [7:0] ch_m;
  state_t     letter_nxt, eff_state;

  assign in_ready   = (level_q <= LW'(FIFO_DEPTH - 1));
  assign tok_valid  = (level_q != '0);
  // Gate with tok_valid so a popped entry left in storage never shows.
  assign tok_kind   = tok_valid & mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign word_cnt   = cnt_q;

  always_comb begin
    is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
    is_letter = is_upper || ((in_char >= 8'h61) && (in_char <= 8'h7A));
    ch_m      = in_char;
`ifdef BLOCK_TOKENIZER_CASE_FOLD_EN
    if (is_upper) ch_m = in_char | 8'h20;
`endif
    accept = in_valid && in_ready;
    pop    = tok_valid && tok_ready;

    letter_nxt = S_WORD;
    case (state_q)
      S_GAP:   if (ch_m == "b") letter_nxt = S_B;
               else if (ch_m == "e") letter_nxt = S_E;
      S_B:     if (ch_m == "e") letter_nxt = S_BE;
      S_BE:    if (ch_m == "g") letter_nxt = S_BEG;
      S_BEG:   if (ch_m == "i") letter_nxt = S_BEGI;
      S_BEGI:  if (ch_m == "n") letter_nxt = S_BEGIN;
      S_E:     if (ch_m == "n") letter_nxt = S_EN;
      S_EN:    if (ch_m == "d") letter_nxt = S_END;
      default: letter_nxt = S_WORD;
    endcase

    // A letter carrying in_last is judged on its post-letter state, as if
    // the implicit delimiter arrived in the same cycle.
    eff_state = is_letter ? letter_nxt : state_q;

    state_d   = state_q;
    push      = 1'b0;
    push_kind = 1'b0;
    if (accept) begin
      if (is_letter && !in_last) begin
        state_d = letter_nxt;
      end else begin
        push      = (eff_state == S_BEGIN) || (eff_state == S_END);
        push_kind = (eff_state == S_BEGIN);
        state_d   = S_GAP;
      end
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_kind;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    cnt_d = cnt_q;
    if (push && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_GAP;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_block_word_tokenizer.sv
module tb_block_word_tokenizer;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_char = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          tok_valid;
  logic          tok_kind;
  logic          tok_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic [CW-1:0] word_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: word buffer, token queue, push counter.
  byte m_word[$];
  bit  m_q[$];
  int  m_cnt = 0;
  int  m_pops = 0;

  always #5 clk = ~clk;

  block_word_tokenizer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_char(in_char), .in_last(in_last), .in_ready(in_ready),
    .tok_valid(tok_valid), .tok_kind(tok_kind), .tok_ready(tok_ready),
    .fifo_level(fifo_level), .word_cnt(word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit word_is(input string s);
    if (m_word.size() != s.len()) return 1'b0;
    for (int i = 0; i < s.len(); i++)
      if (m_word[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_char(input byte ch, input bit last);
    bit up, low;
    byte c;
    up  = (ch >= "A") && (ch <= "Z");
    low = (ch >= "a") && (ch <= "z");
    c = ch;
`ifdef BLOCK_TOKENIZER_CASE_FOLD_EN
    if (up) c = ch + 8'd32;
`endif
    if (up || low) m_word.push_back(c);
    if (!(up || low) || last) begin
      if (word_is("begin") || word_is("end")) begin
        m_q.push_back(word_is("begin"));
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      m_word.delete();
    end
  endfunction

  task automatic check_outputs();
    chk("in_ready",   in_ready,   (m_q.size() < DEPTH));
    chk("tok_valid",  tok_valid,  (m_q.size() != 0));
    chk("tok_kind",   tok_kind,   (m_q.size() != 0) ? m_q[0] : 1'b0);
    chk("fifo_level", fifo_level, m_q.size());
    chk("word_cnt",   word_cnt,   m_cnt);
  endtask

  // One clock: check at negedge, drive, let the edge happen, update model.
  task automatic cycle(input bit v, input byte ch, input bit last, input bit rdy, output bit acc);
    bit pop;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_char = ch; in_last = last; tok_ready = rdy;
    acc = v && (m_q.size() < DEPTH);
    pop = rdy && (m_q.size() != 0);
    @(posedge clk);
    if (pop) begin
      void'(m_q.pop_front());
      m_pops++;
    end
    if (acc) model_char(ch, last);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy, acc);
  endtask

  task automatic send_char(input byte ch, input bit last, input bit rdy);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, ch, last, rdy, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s, input bit rdy, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], last_on_final && (i == s.len() - 1), rdy);
  endtask

  task automatic model_clear();
    m_word.delete();
    m_q.delete();
    m_cnt = 0;
    m_pops = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; tok_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("rst_in_ready",  in_ready,   1);
    chk("rst_tok_valid", tok_valid,  0);
    chk("rst_tok_kind",  tok_kind,   0);
    chk("rst_level",     fifo_level, 0);
    chk("rst_word_cnt",  word_cnt,   0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    string words[9];
    byte   stream[$];
    bit    acc;
    words = '{"begin", "end", "beginx", "endd", "be", "ending", "BEGIN", "Begin", "x"};

    do_reset();

    // Two words with the consumer always ready.
    send_str("begin end ", 1'b1, 1'b0);
    idle(4, 1'b1);
    #1;
    chk("t1_cnt",   word_cnt,   2);
    chk("t1_level", fifo_level, 0);
    chk("t1_pops",  m_pops,     2);

    // Near-miss words produce nothing.
    do_reset();
    send_str("beginx endd be ending ", 1'b1, 1'b0);
    idle(3, 1'b1);
    #1;
    chk("t2_cnt", word_cnt, 0);

    // Fill the FIFO, stall the fifth word until one pop.
    do_reset();
    send_str("end end end end ", 1'b0, 1'b0);
    #1;
    chk("t3_level_full", fifo_level, 4);
    chk("t3_in_ready",   in_ready,   0);
    cycle(1'b1, "e", 1'b0, 1'b1, acc);
    chk("t3_blocked", acc, 0);
    send_str("end ", 1'b0, 1'b0);
    idle(8, 1'b1);
    #1;
    chk("t3_pops", m_pops,   5);
    chk("t3_cnt",  word_cnt, 5);

    // in_last on the final letter acts as the delimiter.
    do_reset();
    send_str("end", 1'b0, 1'b1);
    #1;
    chk("t4_valid", tok_valid, 1);
    chk("t4_kind",  tok_kind,  0);
    idle(2, 1'b1);

    // Uppercase handling depends on the build option.
    do_reset();
    send_str("BEGIN ", 1'b0, 1'b0);
    #1;
`ifdef BLOCK_TOKENIZER_CASE_FOLD_EN
    chk("t5_cnt", word_cnt, 1);
`else
    chk("t5_cnt", word_cnt, 0);
`endif
    idle(2, 1'b1);

    // Reset mid-word with tokens queued discards everything.
    do_reset();
    send_str("begin end ", 1'b0, 1'b0);
    send_str("begi", 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", tok_valid,  0);
    chk("t6_level", fifo_level, 0);
    chk("t6_cnt",   word_cnt,   0);
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_str("n ", 1'b1, 1'b0);
    idle(2, 1'b1);
    #1;
    chk("t6_no_tok", word_cnt, 0);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit v, last, rdy;
      byte ch;
      if (stream.size() == 0) begin
        string w;
        w = words[$urandom_range(8)];
        for (int i = 0; i < w.len(); i++) stream.push_back(w[i]);
        case ($urandom_range(3))
          0: stream.push_back(".");
          1: stream.push_back(8'h0A);
          default: stream.push_back(" ");
        endcase
      end
      v    = ($urandom_range(3) != 0);
      ch   = stream[0];
      last = ($urandom_range(11) == 0);
      rdy  = ($urandom_range(2) != 0);
      cycle(v, ch, last, rdy, acc);
      if (acc) void'(stream.pop_front());
    end
    idle(6, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
